oam_dma_controller: RTL and testbench

Sprite DMA sequencer and CPU-bus arbiter. It sits between the CPU core and the CPU memory map (the RAM/PRG-ROM wrapper and the PPU registers). A CPU write to the DMA trigger register stalls the CPU, then the block copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAM data port. While idle, the block passes the CPU's bus signals through unchanged.

---
 rtl/oam_dma_if.sv | 29 ++
 rtl/oam_dma_controller.sv | 132 +++++++++++++
 tb/tb_oam_dma_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// CPU-side and memory-map-side signals of the sprite DMA controller.
// The controller uses the slave view; the CPU core and memory-map side use the master view.
interface oam_dma_if;
    logic        cpu_ce;
    logic        cpu_cs_n;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  mem_rdata;
    logic        bus_cs_n;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        cpu_rdy;
    logic        dma_active;
    logic        dma_done;

    modport slave (
        input  cpu_ce, cpu_cs_n, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
        output bus_cs_n, bus_rd, bus_wr, bus_addr, bus_wdata, cpu_rdy, dma_active, dma_done
    );

    modport master (
        output cpu_ce, cpu_cs_n, cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata,
        input  bus_cs_n, bus_rd, bus_wr, bus_addr, bus_wdata, cpu_rdy, dma_active, dma_done
    );
endinterface

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer and CPU-bus arbiter: passes the CPU bus through while idle, and on a
// trigger write stalls the CPU and copies one 256-byte page to the PPU OAM data port.
module oam_dma_controller #(
    parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic      clk,
    input  logic      rst,
    oam_dma_if.slave  io
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   page_q, page_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                odd_q, odd_d;
    logic                dma_done_q, dma_done_d;
    logic                trigger_c;

    logic                bus_cs_n_c;
    logic                bus_rd_c;
    logic                bus_wr_c;
    logic [ADDR_W-1:0]   bus_addr_c;
    logic [DATA_W-1:0]   bus_wdata_c;

    assign trigger_c = io.cpu_ce & io.cpu_wr & ~io.cpu_cs_n & (io.cpu_addr == TRIGGER_ADDR);

    // Sequencer: everything except the done pulse advances only on CPU-cycle boundaries.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        page_d     = page_q;
        data_d     = data_q;
        odd_d      = odd_q;
        dma_done_d = 1'b0;
        if (io.cpu_ce) begin
            odd_d = ~odd_q;
            case (state_q)
                S_IDLE: begin
                    if (trigger_c) begin
                        page_d  = io.cpu_wdata;
                        idx_d   = '0;
                        state_d = S_HALT;
                    end
                end
                // An odd HALT means the following cycle is already even, so no alignment cycle.
                S_HALT:  state_d = odd_q ? S_READ : S_ALIGN;
                S_ALIGN: state_d = S_READ;
                S_READ: begin
                    data_d  = io.mem_rdata;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    idx_d = idx_q + DATA_W'(1);
                    if (idx_q == {DATA_W{1'b1}}) begin
                        state_d    = S_IDLE;
                        dma_done_d = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Bus mux: CPU pass-through in IDLE, DMA source read / OAM write otherwise.
    always_comb begin
        bus_cs_n_c  = 1'b1;
        bus_rd_c    = 1'b0;
        bus_wr_c    = 1'b0;
        bus_addr_c  = {page_q, idx_q};
        bus_wdata_c = data_q;
        case (state_q)
            S_IDLE: begin
                bus_cs_n_c  = io.cpu_cs_n;
                bus_rd_c    = io.cpu_rd;
                bus_wr_c    = io.cpu_wr;
                bus_addr_c  = io.cpu_addr;
                bus_wdata_c = io.cpu_wdata;
            end
            S_READ: begin
                bus_cs_n_c = 1'b0;
                bus_rd_c   = 1'b1;
            end
            S_WRITE: begin
                bus_cs_n_c = 1'b0;
                bus_wr_c   = 1'b1;
                bus_addr_c = OAM_DATA_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            page_q     <= '0;
            data_q     <= '0;
            odd_q      <= 1'b0;
            dma_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            data_q     <= data_d;
            odd_q      <= odd_d;
            dma_done_q <= dma_done_d;
        end
    end

    assign io.bus_cs_n   = bus_cs_n_c;
    assign io.bus_rd     = bus_rd_c;
    assign io.bus_wr     = bus_wr_c;
    assign io.bus_addr   = bus_addr_c;
    assign io.bus_wdata  = bus_wdata_c;
    assign io.cpu_rdy    = (state_q == S_IDLE);
    assign io.dma_active = (state_q != S_IDLE);
    assign io.dma_done   = dma_done_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Randomised bench for oam_dma_controller: a byte-array memory map plus a transfer-level model
// of what the OAM port must see (order, data, cycle parity, stall length, done pulse).
module tb_oam_dma_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_if io ();

    oam_dma_controller #(
        .TRIGGER_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    logic [7:0] mem [0:65535];

    // Memory map: read data valid one clk after the address.
    always @(posedge clk) io.mem_rdata <= mem[io.bus_addr];

    int done_cnt = 0;
    always @(negedge clk) if (io.dma_done) done_cnt++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Parity of the current CPU cycle as the bench counts it.
    bit          par;
    logic        s_rdy, s_act, s_cs_n, s_rd, s_wr;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;

    logic [7:0]  wr_q[$];
    bit          wr_par_q[$];
    logic [15:0] rd_q[$];
    bit          rd_par_q[$];

    // One CPU cycle: drive inputs, wait 1-3 clks, pulse cpu_ce, sample bus just before the edge.
    task automatic cpu_cycle(input logic cs_n, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [7:0] wdata);
        io.cpu_cs_n  = cs_n;
        io.cpu_rd    = rd;
        io.cpu_wr    = wr;
        io.cpu_addr  = addr;
        io.cpu_wdata = wdata;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        io.cpu_ce = 1'b1;
        #1;
        s_rdy   = io.cpu_rdy;
        s_act   = io.dma_active;
        s_cs_n  = io.bus_cs_n;
        s_rd    = io.bus_rd;
        s_wr    = io.bus_wr;
        s_addr  = io.bus_addr;
        s_wdata = io.bus_wdata;
        if (!s_rdy && !s_cs_n) begin
            if (s_rd) begin
                rd_q.push_back(s_addr);
                rd_par_q.push_back(par);
            end
            if (s_wr && s_addr == 16'h2004) begin
                wr_q.push_back(s_wdata);
                wr_par_q.push_back(par);
            end
        end
        @(negedge clk);
        io.cpu_ce = 1'b0;
        par = ~par;
    endtask

    task automatic idle_cycle();
        cpu_cycle(1'b1, 1'b0, 1'b0, 16'($urandom), 8'($urandom));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        par = 1'b0;
        #1;
    endtask

    // Full or aborted transfer of one page, checked against the memory contents.
    task automatic run_dma(input logic [7:0] page, input bit want_par, input bit poke,
                           input logic [7:0] poke_page, input int abort_at);
        int  stall;
        int  cyc;
        int  done0;
        int  bad_par;
        int  bad_addr;
        bit  p;
        bit  aborted;
        wr_q.delete(); wr_par_q.delete(); rd_q.delete(); rd_par_q.delete();
        done0 = done_cnt;
        if (par != want_par) idle_cycle();
        p = par;
        cpu_cycle(1'b0, 1'b0, 1'b1, 16'h4014, page);
        check("trig_pass_addr", 32'(s_addr), 32'h4014);
        check("trig_pass_wr", 32'({s_cs_n, s_wr, s_wdata}), 32'({1'b0, 1'b1, page}));
        stall = 0;
        cyc = 0;
        aborted = 1'b0;
        while (cyc < 600) begin
            if (poke && wr_q.size() < 200)
                cpu_cycle(1'b0, 1'b0, 1'b1, 16'h4014, poke_page);
            else
                idle_cycle();
            cyc++;
            if (s_rdy) break;
            stall++;
            if (abort_at >= 0 && rd_q.size() > abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            pulse_reset();
            check("abort_rdy", 32'(io.cpu_rdy), 32'd1);
            check("abort_active", 32'(io.dma_active), 32'd0);
            repeat (4) idle_cycle();
            check("abort_no_more_wr", 32'(wr_q.size()), 32'(abort_at));
            return;
        end
        check("no_timeout", 32'(cyc < 600), 32'd1);
        check("stall_len", 32'(stall), 32'(513 + int'(p)));
        check("wr_count", 32'(wr_q.size()), 32'd256);
        check("rd_count", 32'(rd_q.size()), 32'd256);
        bad_par = 0;
        bad_addr = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++) begin
            check($sformatf("wr_data[%0d]", i), 32'(wr_q[i]), 32'(mem[{page, 8'(i)}]));
            if (wr_par_q[i] != 1'b1) bad_par++;
        end
        for (int i = 0; i < rd_q.size() && i < 256; i++) begin
            if (rd_q[i] != {page, 8'(i)}) bad_addr++;
            if (rd_par_q[i] != 1'b0) bad_par++;
        end
        check("rd_addr_errs", 32'(bad_addr), 32'd0);
        check("parity_errs", 32'(bad_par), 32'd0);
        if (rd_q.size() > 0) check("first_rd_addr", 32'(rd_q[0]), 32'({page, 8'h00}));
        check("done_pulses", 32'(done_cnt - done0), 32'd1);
        check("rdy_after", 32'(s_rdy), 32'd1);
        check("active_after", 32'(s_act), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        io.cpu_ce = 1'b0; io.cpu_cs_n = 1'b1; io.cpu_rd = 1'b0; io.cpu_wr = 1'b0;
        io.cpu_addr = 16'h0000; io.cpu_wdata = 8'h00;
        par = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
        mem[16'h07FF] = 8'h3C;
        repeat (3) @(negedge clk);
        pulse_reset();
        check("rst_rdy", 32'(io.cpu_rdy), 32'd1);
        check("rst_active", 32'(io.dma_active), 32'd0);
        check("rst_done", 32'(io.dma_done), 32'd0);

        cpu_cycle(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);
        check("idle_rd_addr", 32'(s_addr), 32'h8000);
        check("idle_rd_strobe", 32'({s_cs_n, s_rd, s_wr}), 32'b010);
        check("idle_rdy", 32'({s_rdy, s_act}), 32'b10);

        run_dma(8'h02, 1'b0, 1'b0, 8'h00, -1);
        run_dma(8'h02, 1'b1, 1'b0, 8'h00, -1);

        run_dma(8'h07, 1'($urandom), 1'b0, 8'h00, -1);
        if (wr_q.size() > 0) check("last_wr_07ff", 32'(wr_q[wr_q.size() - 1]), 32'h3C);
        check("no_rd_0800", 32'(rd_q.size() > 0 && rd_q[rd_q.size() - 1] == 16'h0800), 32'd0);

        run_dma(8'h02, 1'b0, 1'b0, 8'h00, 100);
        run_dma(8'h02, 1'($urandom), 1'b0, 8'h00, -1);

        run_dma(8'h02, 1'b1, 1'b1, 8'h55, -1);

        for (int k = 0; k < 3; k++)
            run_dma(8'($urandom), 1'($urandom), 1'b0, 8'h00, -1);

        // Reset and trigger on the same edge: no transfer may start.
        @(negedge clk);
        io.cpu_cs_n = 1'b0; io.cpu_wr = 1'b1; io.cpu_rd = 1'b0;
        io.cpu_addr = 16'h4014; io.cpu_wdata = 8'h02;
        io.cpu_ce = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        io.cpu_ce = 1'b0;
        rst = 1'b0;
        par = 1'b0;
        #1;
        check("rst_trig_rdy", 32'(io.cpu_rdy), 32'd1);
        repeat (3) idle_cycle();
        check("rst_trig_still_idle", 32'({s_rdy, s_act}), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
